data_collector: RTL and testbench

- Deserializer; the receive-side counterpart of the 56-bit-to-8-bit data feeder.
- Accepts a stream of signed 8-bit elements (e.g. systolic-array row results) with valid/ready handshake and packs them MSB-first into a 56-bit word.
- Presents the packed word on a registered valid/ready output port.
- Packing order is the exact inverse of the feeder, so feeder -> collector is an identity path for the wide word.

---
 rtl/data_collector.sv | 81 ++++++++
 tb/tb_data_collector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_collector.sv
// Deserializer: packs a stream of in_width-bit elements MSB-first into one out_width-bit word,
// presented on a registered valid/ready port; a flush emits a left-aligned partial word.
module data_collector #(
  parameter int in_width  = 8,
  parameter int out_width = 56,
  localparam int NUM = out_width / in_width,
  localparam int CW  = $clog2(NUM + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [in_width-1:0] data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [out_width-1:0]       data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_count
);

  logic [out_width-1:0] asm_q, asm_d;
  logic [out_width-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;

  logic                 slot_free;
  logic                 accept;
  logic                 complete;
  logic                 flush_go;
  logic [CW-1:0]        k;
  logic [out_width-1:0] assembled;

  // Only the completing element can stall; partial elements always land in the assembly register.
  assign slot_free = !valid_q || out_ready;
  assign in_ready  = !reset && !(cnt_q == CW'(NUM - 1) && !slot_free);
  assign accept    = in_valid && in_ready;
  assign k         = cnt_q + CW'(accept);
  assign assembled = accept ? {asm_q[out_width-in_width-1:0], data_in} : asm_q;
  assign complete  = accept && (cnt_q == CW'(NUM - 1));
  assign flush_go  = flush && slot_free && (k != '0);

  // A short word is shifted up so its first element sits at the MSB end, zeros below.
  always_comb begin
    asm_d   = assembled;
    cnt_d   = k;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    if (complete || flush_go) begin
      data_d  = assembled << (in_width * (NUM - int'(k)));
      count_d = k;
      valid_d = 1'b1;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_data_collector.sv
// Bench for data_collector: directed scenarios plus random traffic, checked against a
// queue-based model of which elements were received and which words were emitted.
module tb_data_collector;

  localparam int IW  = 8;
  localparam int OW  = 56;
  localparam int NUM = OW / IW;
  localparam int CW  = $clog2(NUM + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [IW-1:0] data_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [OW-1:0]        data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_count;

  always #5 clk = ~clk;

  data_collector #(.in_width(IW), .out_width(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model state: elements received since the last emission, and the word on the output port.
  logic [IW-1:0] pending[$];
  logic [OW-1:0] expData;
  logic          expValid;
  logic [CW-1:0] expCount;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    check({where, " out_valid"}, 64'(out_valid), 64'(expValid));
    check({where, " data_out"},  64'(data_out),  64'(expData));
    check({where, " out_count"}, 64'(out_count), 64'(expCount));
  endtask

  task automatic modelReset();
    pending.delete();
    expData  = '0;
    expValid = 1'b0;
    expCount = '0;
  endtask

  // One clock cycle: drive inputs, predict in_ready and the emission, then check after the edge.
  task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic f, input logic r,
                               input string where);
    logic          expReady;
    logic          slotFree;
    logic [OW-1:0] w;
    in_valid  = v;
    data_in   = d;
    flush     = f;
    out_ready = r;
    #1;
    expReady = !(pending.size() == NUM - 1 && expValid && !r);
    check({where, " in_ready"}, 64'(in_ready), 64'(expReady));
    slotFree = !expValid || r;
    if (v && expReady) pending.push_back(d);
    if (pending.size() == NUM || (f && slotFree && pending.size() > 0)) begin
      w = '0;
      foreach (pending[i]) w[OW-1-IW*i -: IW] = pending[i];
      expData  = w;
      expCount = CW'(pending.size());
      expValid = 1'b1;
      pending.delete();
    end else if (expValid && r) begin
      expValid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput(where);
  endtask

  initial begin
    logic [OW-1:0] feedWord;
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    modelReset();
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic packing with a free output.
    for (int i = 1; i <= NUM; i++) applyStimulus(1'b1, IW'(8'h11 * i), 1'b0, 1'b1, "basic");
    check("basic word", 64'(data_out), 64'h0011223344556677);
    check("basic count", 64'(out_count), 64'd7);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "basic drain");
    check("basic one-cycle pulse", 64'(out_valid), 64'd0);

    // Back-to-back words, no bubbles.
    for (int i = 1; i <= 2 * NUM; i++) begin
      applyStimulus(1'b1, IW'(i), 1'b0, 1'b1, "b2b");
      if (i == NUM) check("b2b word0", 64'(data_out), 64'h0001020304050607);
    end
    check("b2b word1", 64'(data_out), 64'h0008090A0B0C0D0E);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "b2b drain");

    // Backpressure: word A held, B stalls on its completing element.
    for (int i = 0; i < NUM; i++) applyStimulus(1'b1, IW'(8'hA0 + i), 1'b0, 1'b0, "bp A");
    for (int i = 0; i < NUM - 1; i++) applyStimulus(1'b1, IW'(8'hB0 + i), 1'b0, 1'b0, "bp B");
    applyStimulus(1'b1, 8'hB6, 1'b0, 1'b0, "bp stall");
    check("bp A held", 64'(data_out), 64'h00A0A1A2A3A4A5A6);
    applyStimulus(1'b1, 8'hB6, 1'b0, 1'b1, "bp release");
    check("bp B word", 64'(data_out), 64'h00B0B1B2B3B4B5B6);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "bp drain");

    // Flush of a partial word, then flush with nothing collected.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, "flush");
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1, "flush");
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1, "flush");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, "flush go");
    check("flush word", 64'(data_out), 64'h00AABBCC00000000);
    check("flush count", 64'(out_count), 64'd3);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, "flush empty");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, "flush empty");
    check("flush empty no-op", 64'(out_valid), 64'd0);

    // Flush together with an accepted element.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, "flush same");
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, "flush same");
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, "flush same go");
    check("flush same word", 64'(data_out), 64'h0001020300000000);
    check("flush same count", 64'(out_count), 64'd3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "flush same drain");

    // Asynchronous reset with a held word and four pending elements.
    for (int i = 0; i < NUM; i++) applyStimulus(1'b1, IW'(8'h50 + i), 1'b0, 1'b0, "rst A");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, IW'(8'h60 + i), 1'b0, 1'b0, "rst B");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async reset");
    check("async reset in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM; i++) applyStimulus(1'b1, IW'(8'h70 + i), 1'b0, 1'b1, "fresh");
    check("fresh word", 64'(data_out), 64'h0070717273747576);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "fresh drain");

    // Feeder-style serialization of a wide word is an identity path.
    feedWord = 56'h0123456789ABCD;
    for (int i = 0; i < NUM; i++) applyStimulus(1'b1, feedWord[OW-1-IW*i -: IW], 1'b0, 1'b1, "feeder");
    check("feeder identity", 64'(data_out), 64'(feedWord));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "feeder drain");

    // Random traffic with random flush and backpressure.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 9) < 7, IW'($urandom), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 6, "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
